branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Execution stage directly downstream of the branch reservation station entries.
- Takes the one selected branch/jump (operands, control, predicted/target/sequential PCs, ROB tag) and resolves direction and actual target.
- Buffers results in a 2-entry output queue until granted the common data bus, then broadcasts link value, ROB tag and misprediction/redirect info.
- Back-pressures the RS select logic through issueReady.

Parameters:
- WIDTH, 31, MSB index of data/address words (word = WIDTH+1 bits)
- ROB, 2, MSB index of ROB tag
- C_WIDTH, 7, MSB index of branch control field

Ports:
- clk  in  1  clock
- globalReset  in  1  asynchronous, active-low reset
- execute  in  1  selected RS entry issues this cycle
- instrRob  in  ROB+1  ROB tag of issuing instruction
- instrInfo  in  C_WIDTH+1  branch control
- src1, src2  in  WIDTH+1 (signed)  operands
- predictedAddress  in  WIDTH+1  front-end predicted next PC
- targetAddress  in  WIDTH+1  precomputed target (conditional, JAL)
- branchResult  in  WIDTH+1  sequential PC (PC+4)
- clear, validCommit  in  1  flush request; effective only when both high
- cdbGrant  in  1  CDB arbiter grant for this unit
- issueReady  out  1  unit can accept an issue this cycle
- cdbReq  out  1  head entry valid, requesting CDB
- cdbRobEntry  out  ROB+1  head ROB tag
- cdbResult  out  WIDTH+1  head link value (0 for conditional)
- mispredict  out  1  one-cycle pulse on granted mispredicted entry
- redirectPC  out  WIDTH+1  correct next PC of head entry
- branchTaken  out  1  resolved direction of head entry (predictor update)

Behaviour:
- instrInfo encoding:
  - [4:3] type: 00 conditional, 01 JAL, 10 JALR, 11 no-op.
  - [2:0] funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; other funct3 values resolve not-taken.
  - [7:5] ignored.
  - All-ones (RS reset value) = no-op.
- Resolve, combinational on issue inputs:
  - Conditional: signed compares for BLT/BGE; unsigned reinterpretation for BLTU/BGEU. taken -> actual = targetAddress, else branchResult. result = 0.
  - JAL: taken = 1; actual = targetAddress; result = branchResult.
  - JALR: taken = 1; actual = (src1 + src2) with bit0 forced 0, modulo 2^(WIDTH+1), wrap ignored; result = branchResult.
  - mispred = (actual != predictedAddress).
  - No-op: never enqueued.
- Queue: 2-entry FIFO of {rob, result, actual, taken, mispred}; 1-bit read/write pointers plus count 0..2.
- Enqueue when execute & issueReady & type != 11.
- issueReady = (count < 2) | (count == 2 & cdbGrant). Same-cycle dequeue frees a slot.
- Latency: issue in cycle N -> entry visible at head, cdbReq = 1 in N+1 if queue was empty. No combinational issue-to-CDB path.
- Head outputs (cdbRobEntry, cdbResult, redirectPC, branchTaken) always reflect the head entry; cdbReq = (count != 0).
- Dequeue when cdbReq & cdbGrant. cdbGrant while cdbReq = 0 is ignored.
- mispredict = cdbReq & cdbGrant & head.mispred (combinational), asserted exactly in the broadcast cycle.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance. Pointers wrap 1 -> 0.
- execute while issueReady = 0: issue ignored, nothing enqueued. RS must hold the entry, since it keeps busy until selected & execute under issueReady.
- Flush (clear & validCommit): synchronous. Next cycle count = 0, pointers = 0, cdbReq = 0. Same-cycle enqueue is discarded. A same-cycle grant still drives that cycle's outputs; mispredict is suppressed during flush.
- Reset (globalReset = 0, asynchronous, any time including mid-operation):
  - count = 0, pointers = 0, all entry storage = 0.
  - Outputs: cdbReq 0, cdbRobEntry 0, cdbResult 0, redirectPC 0, branchTaken 0, mispredict 0, issueReady 1.
- Deassertion takes effect at the next clk edge.

Test Plan:
- BEQ, src1 = src2 = 5, targetAddress 0x100, branchResult 0x44, predictedAddress 0x100, rob 3 -> next cycle cdbReq = 1, rob 3, result 0, redirectPC 0x100, branchTaken 1; on grant mispredict = 0.
- BLTU, src1 = 0xFFFFFFFF, src2 = 1, predicted 0x200, target 0x200, seq 0x48 -> not taken, redirectPC 0x48; on grant mispredict = 1 for one cycle. Same operands with BLT -> taken, no mispredict.
- JALR, src1 = 0x1003, src2 = 0x10, seq 0x2C, predicted 0x2C -> redirectPC 0x1012, result 0x2C, mispredict 1 at grant. JAL target 0x80, predicted 0x80 -> mispredict 0.
- Back-pressure: cdbGrant = 0; issue rob 1, 2 -> issueReady = 0, third issue ignored. Grant in the cycle of a new issue (rob 4) -> rob 1 broadcast, rob 4 accepted; subsequent grants give rob 2 then rob 4.
- Flush with 2 entries queued plus a concurrent issue -> next cycle cdbReq = 0, issueReady = 1, no mispredict pulse.
- globalReset low mid-stream with cdbReq = 1 -> cdbReq, mispredict and all head outputs 0 immediately, before the next clk edge. instrInfo = all ones with execute = 1 -> nothing enqueued.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch/jump execution unit: resolves direction and target of the issued
// branch, then holds results in a 2-entry queue until the CDB grants a broadcast.
module branch_resolve_unit #(
    parameter int WIDTH   = 31,
    parameter int ROB     = 2,
    parameter int C_WIDTH = 7
) (
    input  logic                clk,
    input  logic                globalReset,
    input  logic                execute,
    input  logic [ROB:0]        instrRob,
    input  logic [C_WIDTH:0]    instrInfo,
    input  logic signed [WIDTH:0] src1,
    input  logic signed [WIDTH:0] src2,
    input  logic [WIDTH:0]      predictedAddress,
    input  logic [WIDTH:0]      targetAddress,
    input  logic [WIDTH:0]      branchResult,
    input  logic                clear,
    input  logic                validCommit,
    input  logic                cdbGrant,
    output logic                issueReady,
    output logic                cdbReq,
    output logic [ROB:0]        cdbRobEntry,
    output logic [WIDTH:0]      cdbResult,
    output logic                mispredict,
    output logic [WIDTH:0]      redirectPC,
    output logic                branchTaken
);

    typedef enum logic [1:0] {
        BR_COND = 2'b00,
        BR_JAL  = 2'b01,
        BR_JALR = 2'b10,
        BR_NOP  = 2'b11
    } br_type_t;

    typedef struct packed {
        logic [ROB:0]   rob;
        logic [WIDTH:0] result;
        logic [WIDTH:0] actual;
        logic           taken;
        logic           mispred;
    } entry_t;

    br_type_t       br_type;
    logic [2:0]     funct3;
    logic [WIDTH:0] jalr_sum;
    logic           res_taken;
    logic [WIDTH:0] res_actual;
    logic [WIDTH:0] res_result;
    entry_t         new_entry;

    entry_t         mem [2];
    logic           rd_ptr;
    logic           wr_ptr;
    logic [1:0]     count;
    entry_t         head;

    logic           flush;
    logic           enq;
    logic           deq;
    logic           unused_info;

    assign br_type     = br_type_t'(instrInfo[4:3]);
    assign funct3      = instrInfo[2:0];
    assign unused_info = ^instrInfo[C_WIDTH:5];
    assign jalr_sum    = src1 + src2;

    always_comb begin
        res_taken  = 1'b0;
        res_actual = branchResult;
        res_result = '0;
        unique case (br_type)
            BR_COND: begin
                unique case (funct3)
                    3'b000:  res_taken = (src1 == src2);
                    3'b001:  res_taken = (src1 != src2);
                    3'b100:  res_taken = (src1 < src2);
                    3'b101:  res_taken = (src1 >= src2);
                    3'b110:  res_taken = ($unsigned(src1) < $unsigned(src2));
                    3'b111:  res_taken = ($unsigned(src1) >= $unsigned(src2));
                    default: res_taken = 1'b0;
                endcase
                res_actual = res_taken ? targetAddress : branchResult;
            end
            BR_JAL: begin
                res_taken  = 1'b1;
                res_actual = targetAddress;
                res_result = branchResult;
            end
            BR_JALR: begin
                res_taken  = 1'b1;
                res_actual = {jalr_sum[WIDTH:1], 1'b0};
                res_result = branchResult;
            end
            default: begin
                res_taken  = 1'b0;
                res_actual = branchResult;
                res_result = '0;
            end
        endcase
    end

    always_comb begin
        new_entry.rob     = instrRob;
        new_entry.result  = res_result;
        new_entry.actual  = res_actual;
        new_entry.taken   = res_taken;
        new_entry.mispred = (res_actual != predictedAddress);
    end

    assign head        = mem[rd_ptr];
    assign flush       = clear & validCommit;
    assign cdbReq      = (count != 2'd0);
    assign issueReady  = (count < 2'd2) | ((count == 2'd2) & cdbGrant);
    assign deq         = cdbReq & cdbGrant;
    assign enq         = execute & issueReady & (br_type != BR_NOP) & ~flush;

    assign cdbRobEntry = head.rob;
    assign cdbResult   = head.result;
    assign redirectPC  = head.actual;
    assign branchTaken = head.taken;
    assign mispredict  = deq & head.mispred & ~flush;

    always_ff @(posedge clk or negedge globalReset) begin
        if (!globalReset) begin
            count  <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (enq) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (deq) begin
                rd_ptr <= ~rd_ptr;
            end
            // Concurrent enqueue and dequeue leave the occupancy unchanged
            if (enq && !deq) begin
                count <= count + 2'd1;
            end else if (deq && !enq) begin
                count <= count - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit: resolve cases,
// queue back-pressure, flush and asynchronous reset.
module tb_branch_resolve_unit;

    logic        clk;
    logic        globalReset;
    logic        execute;
    logic [2:0]  instrRob;
    logic [7:0]  instrInfo;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] predictedAddress;
    logic [31:0] targetAddress;
    logic [31:0] branchResult;
    logic        clear;
    logic        validCommit;
    logic        cdbGrant;
    logic        issueReady;
    logic        cdbReq;
    logic [2:0]  cdbRobEntry;
    logic [31:0] cdbResult;
    logic        mispredict;
    logic [31:0] redirectPC;
    logic        branchTaken;

    int n_tests = 0;
    int n_fail  = 0;

    branch_resolve_unit #(
        .WIDTH   (31),
        .ROB     (2),
        .C_WIDTH (7)
    ) dut (
        .clk              (clk),
        .globalReset      (globalReset),
        .execute          (execute),
        .instrRob         (instrRob),
        .instrInfo        (instrInfo),
        .src1             (src1),
        .src2             (src2),
        .predictedAddress (predictedAddress),
        .targetAddress    (targetAddress),
        .branchResult     (branchResult),
        .clear            (clear),
        .validCommit      (validCommit),
        .cdbGrant         (cdbGrant),
        .issueReady       (issueReady),
        .cdbReq           (cdbReq),
        .cdbRobEntry      (cdbRobEntry),
        .cdbResult        (cdbResult),
        .mispredict       (mispredict),
        .redirectPC       (redirectPC),
        .branchTaken      (branchTaken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one issue for a single cycle
    task automatic issue(input logic [2:0] rob, input logic [7:0] info,
                         input logic [31:0] s1, input logic [31:0] s2,
                         input logic [31:0] pred, input logic [31:0] tgt,
                         input logic [31:0] seq);
        execute          = 1'b1;
        instrRob         = rob;
        instrInfo        = info;
        src1             = s1;
        src2             = s2;
        predictedAddress = pred;
        targetAddress    = tgt;
        branchResult     = seq;
        tick();
        execute          = 1'b0;
    endtask

    task automatic grant_one();
        cdbGrant = 1'b1;
        tick();
        cdbGrant = 1'b0;
    endtask

    initial begin
        globalReset = 1'b0;
        execute = 1'b0; instrRob = '0; instrInfo = '1;
        src1 = '0; src2 = '0; predictedAddress = '0; targetAddress = '0; branchResult = '0;
        clear = 1'b0; validCommit = 1'b0; cdbGrant = 1'b0;
        tick();
        check_eq("rst_cdbReq", {31'd0, cdbReq}, 32'd0);
        check_eq("rst_issueReady", {31'd0, issueReady}, 32'd1);
        check_eq("rst_redirect", redirectPC, 32'd0);
        globalReset = 1'b1;
        tick();

        // BEQ equal, correctly predicted
        issue(3'd3, 8'h00, 32'd5, 32'd5, 32'h100, 32'h100, 32'h44);
        check_eq("beq_cdbReq", {31'd0, cdbReq}, 32'd1);
        check_eq("beq_rob", {29'd0, cdbRobEntry}, 32'd3);
        check_eq("beq_result", cdbResult, 32'd0);
        check_eq("beq_redirect", redirectPC, 32'h100);
        check_eq("beq_taken", {31'd0, branchTaken}, 32'd1);
        cdbGrant = 1'b1; #1;
        check_eq("beq_mispred", {31'd0, mispredict}, 32'd0);
        tick(); cdbGrant = 1'b0;
        check_eq("beq_drained", {31'd0, cdbReq}, 32'd0);

        // BLTU: 0xFFFFFFFF < 1 unsigned is false -> not taken, mispredicted
        issue(3'd1, 8'h06, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h200, 32'h48);
        check_eq("bltu_taken", {31'd0, branchTaken}, 32'd0);
        check_eq("bltu_redirect", redirectPC, 32'h48);
        cdbGrant = 1'b1; #1;
        check_eq("bltu_mispred", {31'd0, mispredict}, 32'd1);
        tick(); cdbGrant = 1'b0; #1;
        check_eq("bltu_pulse_end", {31'd0, mispredict}, 32'd0);

        // BLT: -1 < 1 signed -> taken, matches prediction
        issue(3'd2, 8'h04, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h200, 32'h48);
        check_eq("blt_taken", {31'd0, branchTaken}, 32'd1);
        check_eq("blt_redirect", redirectPC, 32'h200);
        cdbGrant = 1'b1; #1;
        check_eq("blt_mispred", {31'd0, mispredict}, 32'd0);
        tick(); cdbGrant = 1'b0;

        // JALR: 0x1003 + 0x10 = 0x1013, bit0 cleared -> 0x1012
        issue(3'd5, 8'h10, 32'h1003, 32'h10, 32'h2C, 32'h0, 32'h2C);
        check_eq("jalr_redirect", redirectPC, 32'h1012);
        check_eq("jalr_result", cdbResult, 32'h2C);
        check_eq("jalr_taken", {31'd0, branchTaken}, 32'd1);
        cdbGrant = 1'b1; #1;
        check_eq("jalr_mispred", {31'd0, mispredict}, 32'd1);
        tick(); cdbGrant = 1'b0;

        // JAL correctly predicted
        issue(3'd6, 8'h08, 32'h0, 32'h0, 32'h80, 32'h80, 32'h30);
        check_eq("jal_redirect", redirectPC, 32'h80);
        check_eq("jal_result", cdbResult, 32'h30);
        cdbGrant = 1'b1; #1;
        check_eq("jal_mispred", {31'd0, mispredict}, 32'd0);
        tick(); cdbGrant = 1'b0;

        // Back-pressure
        issue(3'd1, 8'h08, 32'h0, 32'h0, 32'h80, 32'h80, 32'h11);
        issue(3'd2, 8'h08, 32'h0, 32'h0, 32'h80, 32'h80, 32'h22);
        check_eq("bp_full_ready", {31'd0, issueReady}, 32'd0);
        issue(3'd5, 8'h08, 32'h0, 32'h0, 32'h80, 32'h80, 32'h55);
        check_eq("bp_ignored_head", {29'd0, cdbRobEntry}, 32'd1);
        execute = 1'b1; instrRob = 3'd4; branchResult = 32'h44; cdbGrant = 1'b1; #1;
        check_eq("bp_grant_ready", {31'd0, issueReady}, 32'd1);
        check_eq("bp_bcast_rob1", {29'd0, cdbRobEntry}, 32'd1);
        tick(); execute = 1'b0; cdbGrant = 1'b0;
        check_eq("bp_head_rob2", {29'd0, cdbRobEntry}, 32'd2);
        check_eq("bp_head_res2", cdbResult, 32'h22);
        grant_one();
        check_eq("bp_head_rob4", {29'd0, cdbRobEntry}, 32'd4);
        check_eq("bp_head_res4", cdbResult, 32'h44);
        grant_one();
        check_eq("bp_empty", {31'd0, cdbReq}, 32'd0);

        // clear without validCommit has no effect
        issue(3'd7, 8'h00, 32'd1, 32'd1, 32'h300, 32'h300, 32'h50);
        clear = 1'b1; tick(); clear = 1'b0;
        check_eq("clear_only_keep", {31'd0, cdbReq}, 32'd1);
        grant_one();

        // Flush with two entries queued, mispredicted head, concurrent issue and grant
        issue(3'd6, 8'h00, 32'd1, 32'd2, 32'h300, 32'h300, 32'h60);
        issue(3'd7, 8'h08, 32'h0, 32'h0, 32'h80, 32'h80, 32'h70);
        execute = 1'b1; instrRob = 3'd2; clear = 1'b1; validCommit = 1'b1; cdbGrant = 1'b1; #1;
        check_eq("flush_no_mispred", {31'd0, mispredict}, 32'd0);
        tick();
        execute = 1'b0; clear = 1'b0; validCommit = 1'b0; cdbGrant = 1'b0;
        check_eq("flush_cdbReq", {31'd0, cdbReq}, 32'd0);
        check_eq("flush_ready", {31'd0, issueReady}, 32'd1);
        tick();
        check_eq("flush_discarded", {31'd0, cdbReq}, 32'd0);

        // Asynchronous reset mid-stream
        issue(3'd5, 8'h10, 32'h1003, 32'h10, 32'h2C, 32'h0, 32'h2C);
        check_eq("ar_pre_req", {31'd0, cdbReq}, 32'd1);
        cdbGrant = 1'b1; #1;
        globalReset = 1'b0; #1;
        check_eq("ar_cdbReq", {31'd0, cdbReq}, 32'd0);
        check_eq("ar_mispred", {31'd0, mispredict}, 32'd0);
        check_eq("ar_rob", {29'd0, cdbRobEntry}, 32'd0);
        check_eq("ar_result", cdbResult, 32'd0);
        check_eq("ar_redirect", redirectPC, 32'd0);
        check_eq("ar_taken", {31'd0, branchTaken}, 32'd0);
        check_eq("ar_ready", {31'd0, issueReady}, 32'd1);
        cdbGrant = 1'b0;
        tick();
        globalReset = 1'b1;
        tick();

        // All-ones control is a no-op
        issue(3'd3, 8'hFF, 32'd5, 32'd5, 32'h100, 32'h100, 32'h44);
        check_eq("nop_not_queued", {31'd0, cdbReq}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
